// File: rtl/in_potentio_multi.sv
// Multi-channel potentiometer input: per-channel block averaging, NEW/THR flags,
// maskable level interrupt and an AXI4-Lite register file on S00_AXI.
module in_potentio_multi #(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 6,
    parameter int NUM_CH               = 4,
    parameter int SAMPLE_WIDTH         = 12,
    parameter int AVG_LOG2             = 2
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0]    sample_i,
    input  logic [NUM_CH-1:0]                 sample_valid_i,
    output logic                              irq_o,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready
);

    localparam int AW = SAMPLE_WIDTH + AVG_LOG2;
    localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((32'd1 << AVG_LOG2) - 32'd1);
    localparam logic [31:0]   ID_VALUE = {8'h02, 8'(NUM_CH), 8'(SAMPLE_WIDTH), 8'(AVG_LOG2)};

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    w_state_t w_state_r, w_next_s;
    r_state_t r_state_r, r_next_s;
    logic     aw_hs_s, ar_hs_s;

    logic                    ctrl_en_r;
    logic [7:0]              irq_mask_r;
    logic [SAMPLE_WIDTH-1:0] thresh_r;
    logic [NUM_CH-1:0]       new_r, thr_r;
    logic [AW-1:0]           acc_r     [NUM_CH];
    logic [CW-1:0]           cnt_r     [NUM_CH];
    logic [SAMPLE_WIDTH-1:0] ch_data_r [NUM_CH];
    logic                    irq_r;
    logic [31:0]             rdata_r;

    logic                    ctrl_sel_s, stat_sel_s, thr_sel_s, clr_s;
    logic [NUM_CH-1:0]       w1c_new_s, w1c_thr_s;
    logic [31:0]             thresh_wr_s;
    logic [AW-1:0]           sum_s     [NUM_CH];
    logic [SAMPLE_WIDTH-1:0] avg_s     [NUM_CH];
    logic [NUM_CH-1:0]       done_s, step_s, gt_s;
    logic [3:0]              rd_idx_s, ch_idx_s;
    logic [31:0]             ch_rd_s, rd_val_s;

    logic unused_s;
    assign unused_s = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                        s00_axi_araddr[1:0], thresh_wr_s[31:SAMPLE_WIDTH]};

    // Write-channel state register.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) w_state_r <= W_IDLE;
        else                w_state_r <= w_next_s;
    end

    // Write-channel next state; AW and W are accepted together or not at all.
    always_comb begin
        w_next_s = w_state_r;
        aw_hs_s  = 1'b0;
        case (w_state_r)
            W_IDLE: begin
                if (s00_axi_awvalid && s00_axi_wvalid && !s00_axi_areset) begin
                    aw_hs_s  = 1'b1;
                    w_next_s = W_RESP;
                end else begin
                    w_next_s = W_IDLE;
                end
            end
            W_RESP: begin
                if (s00_axi_bready) w_next_s = W_IDLE;
                else                w_next_s = W_RESP;
            end
            default: w_next_s = W_IDLE;
        endcase
    end

    assign s00_axi_awready = aw_hs_s;
    assign s00_axi_wready  = aw_hs_s;
    assign s00_axi_bvalid  = (w_state_r == W_RESP) && !s00_axi_areset;
    assign s00_axi_bresp   = 2'b00;

    // Register-write decode, committed on the AW/W handshake edge.
    always_comb begin
        ctrl_sel_s  = aw_hs_s && (s00_axi_awaddr[5:2] == 4'd0);
        stat_sel_s  = aw_hs_s && (s00_axi_awaddr[5:2] == 4'd1);
        thr_sel_s   = aw_hs_s && (s00_axi_awaddr[5:2] == 4'd2);
        clr_s       = ctrl_sel_s && s00_axi_wstrb[0] && s00_axi_wdata[1];
        w1c_new_s   = (stat_sel_s && s00_axi_wstrb[0]) ? s00_axi_wdata[NUM_CH-1:0] : {NUM_CH{1'b0}};
        w1c_thr_s   = (stat_sel_s && s00_axi_wstrb[1]) ? s00_axi_wdata[8 +: NUM_CH] : {NUM_CH{1'b0}};
        thresh_wr_s = apply_strb({{(32-SAMPLE_WIDTH){1'b0}}, thresh_r}, s00_axi_wdata, s00_axi_wstrb);
    end

    // Per-channel accumulate / block-complete decisions.
    always_comb begin
        done_s = {NUM_CH{1'b0}};
        step_s = {NUM_CH{1'b0}};
        gt_s   = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            sum_s[i]  = acc_r[i] + AW'(sample_i[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
            avg_s[i]  = SAMPLE_WIDTH'(sum_s[i] >> AVG_LOG2);
            done_s[i] = ctrl_en_r && sample_valid_i[i] && (cnt_r[i] == CNT_LAST);
            step_s[i] = ctrl_en_r && sample_valid_i[i] && (cnt_r[i] != CNT_LAST);
            gt_s[i]   = done_s[i] && (avg_s[i] > thresh_r);
        end
    end

    // Control registers, averaging datapath, flags and interrupt.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            ctrl_en_r  <= 1'b0;
            irq_mask_r <= 8'h00;
            thresh_r   <= {SAMPLE_WIDTH{1'b0}};
            new_r      <= {NUM_CH{1'b0}};
            thr_r      <= {NUM_CH{1'b0}};
            irq_r      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_r[i]     <= {AW{1'b0}};
                cnt_r[i]     <= {CW{1'b0}};
                ch_data_r[i] <= {SAMPLE_WIDTH{1'b0}};
            end
        end else begin
            if (ctrl_sel_s && s00_axi_wstrb[0]) ctrl_en_r  <= s00_axi_wdata[0];
            if (ctrl_sel_s && s00_axi_wstrb[1]) irq_mask_r <= s00_axi_wdata[15:8];
            if (thr_sel_s)                      thresh_r   <= thresh_wr_s[SAMPLE_WIDTH-1:0];
            if (clr_s) begin
                new_r <= {NUM_CH{1'b0}};
                thr_r <= {NUM_CH{1'b0}};
                for (int i = 0; i < NUM_CH; i++) begin
                    acc_r[i]     <= {AW{1'b0}};
                    cnt_r[i]     <= {CW{1'b0}};
                    ch_data_r[i] <= {SAMPLE_WIDTH{1'b0}};
                end
            end else begin
                // A flag being set wins over a simultaneous write-one-to-clear.
                new_r <= (new_r & ~w1c_new_s) | done_s;
                thr_r <= (thr_r & ~w1c_thr_s) | gt_s;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (done_s[i]) begin
                        ch_data_r[i] <= avg_s[i];
                        acc_r[i]     <= {AW{1'b0}};
                        cnt_r[i]     <= {CW{1'b0}};
                    end else if (step_s[i]) begin
                        acc_r[i] <= sum_s[i];
                        cnt_r[i] <= cnt_r[i] + CW'(32'd1);
                    end
                end
            end
            irq_r <= |((new_r | thr_r) & irq_mask_r[NUM_CH-1:0]);
        end
    end

    assign irq_o = irq_r;

    // Read-channel state register.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) r_state_r <= R_IDLE;
        else                r_state_r <= r_next_s;
    end

    // Read-channel next state.
    always_comb begin
        r_next_s = r_state_r;
        ar_hs_s  = 1'b0;
        case (r_state_r)
            R_IDLE: begin
                if (s00_axi_arvalid && !s00_axi_areset) begin
                    ar_hs_s  = 1'b1;
                    r_next_s = R_DATA;
                end else begin
                    r_next_s = R_IDLE;
                end
            end
            R_DATA: begin
                if (s00_axi_rready) r_next_s = R_IDLE;
                else                r_next_s = R_DATA;
            end
            default: r_next_s = R_IDLE;
        endcase
    end

    // Read address decode; channel slots beyond NUM_CH fall through as zero.
    always_comb begin
        rd_idx_s = s00_axi_araddr[5:2];
        ch_idx_s = rd_idx_s - 4'd4;
        ch_rd_s  = 32'h0000_0000;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_rd_s = ch_rd_s | ((ch_idx_s == 4'(c)) ?
                      {{(32-SAMPLE_WIDTH){1'b0}}, ch_data_r[c]} : 32'h0000_0000);
        end
        rd_val_s = 32'h0000_0000;
        case (rd_idx_s)
            4'd0: rd_val_s = {16'h0000, irq_mask_r, 6'b000000, 1'b0, ctrl_en_r};
            4'd1: begin
                rd_val_s[NUM_CH-1:0]  = new_r;
                rd_val_s[8 +: NUM_CH] = thr_r;
            end
            4'd2: rd_val_s = {{(32-SAMPLE_WIDTH){1'b0}}, thresh_r};
            4'd3: rd_val_s = ID_VALUE;
            default: rd_val_s = ch_rd_s;
        endcase
    end

    // Read data is captured on the AR handshake and held until accepted.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset)  rdata_r <= 32'h0000_0000;
        else if (ar_hs_s)    rdata_r <= rd_val_s;
        else                 rdata_r <= rdata_r;
    end

    assign s00_axi_arready = ar_hs_s;
    assign s00_axi_rvalid  = (r_state_r == R_DATA) && !s00_axi_areset;
    assign s00_axi_rdata   = rdata_r;
    assign s00_axi_rresp   = 2'b00;

endmodule

// File: tb/tb_in_potentio_multi.sv
// Directed bench for in_potentio_multi: reads push expected values into a
// scoreboard queue, a monitor pops and compares on each R handshake.
module tb_in_potentio_multi;

    logic        s00_axi_aclk = 1'b0;
    logic        s00_axi_areset;
    logic [47:0] sample_i;
    logic [3:0]  sample_valid_i;
    logic        irq_o;
    logic [5:0]  s00_axi_awaddr;
    logic [2:0]  s00_axi_awprot;
    logic        s00_axi_awvalid, s00_axi_awready;
    logic [31:0] s00_axi_wdata;
    logic [3:0]  s00_axi_wstrb;
    logic        s00_axi_wvalid, s00_axi_wready;
    logic [1:0]  s00_axi_bresp;
    logic        s00_axi_bvalid, s00_axi_bready;
    logic [5:0]  s00_axi_araddr;
    logic [2:0]  s00_axi_arprot;
    logic        s00_axi_arvalid, s00_axi_arready;
    logic [31:0] s00_axi_rdata;
    logic [1:0]  s00_axi_rresp;
    logic        s00_axi_rvalid, s00_axi_rready;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 s00_axi_aclk = ~s00_axi_aclk;

    in_potentio_multi dut (
        .s00_axi_aclk    (s00_axi_aclk),
        .s00_axi_areset  (s00_axi_areset),
        .sample_i        (sample_i),
        .sample_valid_i  (sample_valid_i),
        .irq_o           (irq_o),
        .s00_axi_awaddr  (s00_axi_awaddr),
        .s00_axi_awprot  (s00_axi_awprot),
        .s00_axi_awvalid (s00_axi_awvalid),
        .s00_axi_awready (s00_axi_awready),
        .s00_axi_wdata   (s00_axi_wdata),
        .s00_axi_wstrb   (s00_axi_wstrb),
        .s00_axi_wvalid  (s00_axi_wvalid),
        .s00_axi_wready  (s00_axi_wready),
        .s00_axi_bresp   (s00_axi_bresp),
        .s00_axi_bvalid  (s00_axi_bvalid),
        .s00_axi_bready  (s00_axi_bready),
        .s00_axi_araddr  (s00_axi_araddr),
        .s00_axi_arprot  (s00_axi_arprot),
        .s00_axi_arvalid (s00_axi_arvalid),
        .s00_axi_arready (s00_axi_arready),
        .s00_axi_rdata   (s00_axi_rdata),
        .s00_axi_rresp   (s00_axi_rresp),
        .s00_axi_rvalid  (s00_axi_rvalid),
        .s00_axi_rready  (s00_axi_rready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: handshake timeout, got none, expected one within 20 cycles", name);
    endtask

    // Scoreboard monitor: every accepted read beat is checked against the queue head.
    always @(negedge s00_axi_aclk) begin
        exp_t e;
        if (!s00_axi_areset && s00_axi_rvalid && s00_axi_rready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_read: got 0x%08h, expected no read", s00_axi_rdata);
            end else begin
                e = exp_q.pop_front();
                check(e.name, s00_axi_rdata, e.val);
                check({e.name, "_rresp"}, 32'(s00_axi_rresp), 32'h0);
            end
        end
    end

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] strb);
        bit ok;
        @(posedge s00_axi_aclk); #1;
        s00_axi_awaddr = a; s00_axi_wdata = d; s00_axi_wstrb = strb;
        s00_axi_awvalid = 1'b1; s00_axi_wvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge s00_axi_aclk);
            if (s00_axi_awready) begin ok = 1'b1; break; end
        end
        @(posedge s00_axi_aclk); #1;
        s00_axi_awvalid = 1'b0; s00_axi_wvalid = 1'b0;
        if (!ok) begin
            timeout("write_aw");
        end else begin
            s00_axi_bready = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge s00_axi_aclk);
                if (s00_axi_bvalid) begin ok = 1'b1; break; end
            end
            if (!ok) timeout("write_b");
            @(posedge s00_axi_aclk); #1;
            s00_axi_bready = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [31:0] exp, input string name);
        bit ok;
        exp_q.push_back('{name, exp});
        @(posedge s00_axi_aclk); #1;
        s00_axi_araddr = a; s00_axi_arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge s00_axi_aclk);
            if (s00_axi_arready) begin ok = 1'b1; break; end
        end
        @(posedge s00_axi_aclk); #1;
        s00_axi_arvalid = 1'b0;
        if (!ok) begin
            timeout({name, "_ar"});
            void'(exp_q.pop_back());
        end else begin
            s00_axi_rready = 1'b1;
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge s00_axi_aclk);
                if (s00_axi_rvalid) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                timeout({name, "_r"});
                void'(exp_q.pop_back());
            end
            @(posedge s00_axi_aclk); #1;
            s00_axi_rready = 1'b0;
        end
    endtask

    task automatic strobe(input int ch, input logic [11:0] v);
        @(posedge s00_axi_aclk); #1;
        sample_i[ch*12 +: 12] = v;
        sample_valid_i = 4'b0000;
        sample_valid_i[ch] = 1'b1;
        @(posedge s00_axi_aclk); #1;
        sample_valid_i = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s00_axi_areset = 1'b1;
        sample_i = 48'h0; sample_valid_i = 4'b0000;
        s00_axi_awaddr = 6'h00; s00_axi_awprot = 3'b000; s00_axi_awvalid = 1'b0;
        s00_axi_wdata = 32'h0; s00_axi_wstrb = 4'h0; s00_axi_wvalid = 1'b0; s00_axi_bready = 1'b0;
        s00_axi_araddr = 6'h00; s00_axi_arprot = 3'b000; s00_axi_arvalid = 1'b0; s00_axi_rready = 1'b0;
        repeat (3) @(posedge s00_axi_aclk);
        @(negedge s00_axi_aclk);
        check("rst_irq",    32'(irq_o),           32'h0);
        check("rst_bvalid", 32'(s00_axi_bvalid),  32'h0);
        check("rst_rvalid", 32'(s00_axi_rvalid),  32'h0);
        check("rst_rdata",  s00_axi_rdata,        32'h0);
        @(posedge s00_axi_aclk); #1;
        s00_axi_areset = 1'b0;

        // Reset contents
        axi_read(6'h0C, 32'h0204_0C02, "id");
        axi_read(6'h00, 32'h0, "rst_ctrl");
        axi_read(6'h04, 32'h0, "rst_status");
        axi_read(6'h08, 32'h0, "rst_thresh");
        for (int c = 0; c < 4; c++) axi_read(6'(16 + 4*c), 32'h0, "rst_ch_data");

        // Channel 0 average: (100+200+300+401)/4 = 250; THR[0] set since 250 > 0
        axi_write(6'h00, 32'h0000_0001, 4'hF);
        strobe(0, 12'd100); strobe(0, 12'd200); strobe(0, 12'd300); strobe(0, 12'd401);
        axi_read(6'h10, 32'd250, "ch0_avg");
        axi_read(6'h04, 32'h0000_0101, "status_ch0");
        axi_read(6'h14, 32'h0, "ch1_untouched");
        axi_write(6'h04, 32'h0000_0F0F, 4'hF);
        axi_read(6'h04, 32'h0, "status_cleared");

        // Threshold + interrupt on channel 1: (250+251+252+253)/4 = 251 > 250
        axi_write(6'h08, 32'd250, 4'hF);
        axi_write(6'h00, 32'h0000_0201, 4'hF);
        strobe(1, 12'd250); strobe(1, 12'd251); strobe(1, 12'd252); strobe(1, 12'd253);
        @(negedge s00_axi_aclk);
        check("irq_not_yet", 32'(irq_o), 32'h0);
        @(negedge s00_axi_aclk);
        check("irq_raised", 32'(irq_o), 32'h1);
        axi_read(6'h04, 32'h0000_0202, "status_ch1");
        axi_read(6'h14, 32'd251, "ch1_avg");
        axi_write(6'h04, 32'h0000_0202, 4'hF);
        repeat (2) @(negedge s00_axi_aclk);
        check("irq_cleared", 32'(irq_o), 32'h0);
        axi_read(6'h04, 32'h0, "status_after_w1c");

        // Completion on channel 2 coincides with W1C of NEW[2]: set wins; avg 100/4 = 25
        strobe(2, 12'd10); strobe(2, 12'd20); strobe(2, 12'd30);
        @(posedge s00_axi_aclk); #1;
        s00_axi_awaddr = 6'h04; s00_axi_wdata = 32'h0000_0004; s00_axi_wstrb = 4'hF;
        s00_axi_awvalid = 1'b1; s00_axi_wvalid = 1'b1;
        sample_i[2*12 +: 12] = 12'd40; sample_valid_i = 4'b0100;
        @(negedge s00_axi_aclk);
        check("coinc_awready", 32'(s00_axi_awready), 32'h1);
        @(posedge s00_axi_aclk); #1;
        s00_axi_awvalid = 1'b0; s00_axi_wvalid = 1'b0; sample_valid_i = 4'b0000; s00_axi_bready = 1'b1;
        @(negedge s00_axi_aclk);
        check("coinc_bvalid", 32'(s00_axi_bvalid), 32'h1);
        @(posedge s00_axi_aclk); #1;
        s00_axi_bready = 1'b0;
        axi_read(6'h04, 32'h0000_0004, "status_set_wins");
        axi_read(6'h18, 32'd25, "ch2_avg");
        check("irq_masked", 32'(irq_o), 32'h0);

        // EN=0 ignores strobes
        axi_write(6'h00, 32'h0000_0200, 4'hF);
        for (int k = 0; k < 4; k++) strobe(0, 12'd1000);
        axi_read(6'h10, 32'd250, "ch0_hold_en0");
        axi_read(6'h04, 32'h0000_0004, "status_hold_en0");

        // CLR mid-block on channel 3, then a fresh block of 8s
        axi_write(6'h00, 32'h0000_0201, 4'hF);
        strobe(3, 12'd500); strobe(3, 12'd500);
        axi_write(6'h00, 32'h0000_0203, 4'hF);
        axi_read(6'h00, 32'h0000_0201, "ctrl_after_clr");
        axi_read(6'h04, 32'h0, "status_after_clr");
        axi_read(6'h10, 32'h0, "ch0_after_clr");
        axi_read(6'h18, 32'h0, "ch2_after_clr");
        for (int k = 0; k < 4; k++) strobe(3, 12'd8);
        axi_read(6'h1C, 32'd8, "ch3_post_clr");
        axi_read(6'h04, 32'h0000_0008, "status_ch3");
        axi_read(6'h08, 32'd250, "thresh_kept");

        // AW three cycles ahead of W, bready held low five cycles; byte-lane 0 only
        @(posedge s00_axi_aclk); #1;
        s00_axi_awaddr = 6'h08; s00_axi_wdata = 32'h0000_0123; s00_axi_wstrb = 4'h1;
        s00_axi_awvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge s00_axi_aclk);
            check("early_awready", 32'(s00_axi_awready), 32'h0);
            check("early_wready",  32'(s00_axi_wready),  32'h0);
        end
        @(posedge s00_axi_aclk); #1;
        s00_axi_wvalid = 1'b1;
        @(negedge s00_axi_aclk);
        check("late_awready", 32'(s00_axi_awready), 32'h1);
        check("late_wready",  32'(s00_axi_wready),  32'h1);
        @(posedge s00_axi_aclk); #1;
        s00_axi_awvalid = 1'b0; s00_axi_wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge s00_axi_aclk);
            check("bvalid_hold", 32'(s00_axi_bvalid), 32'h1);
            check("bresp_okay",  32'(s00_axi_bresp),  32'h0);
        end
        @(posedge s00_axi_aclk); #1;
        s00_axi_bready = 1'b1;
        @(negedge s00_axi_aclk);
        check("bvalid_at_ready", 32'(s00_axi_bvalid), 32'h1);
        @(posedge s00_axi_aclk); #1;
        s00_axi_bready = 1'b0;
        @(negedge s00_axi_aclk);
        check("bvalid_dropped", 32'(s00_axi_bvalid), 32'h0);
        axi_read(6'h08, 32'h0000_0023, "thresh_strb");
        axi_read(6'h3C, 32'h0, "unmapped_3c");
        axi_read(6'h20, 32'h0, "ch4_absent");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge s00_axi_aclk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending reads, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/in_potentio_multi.md
# in_potentio_multi

Multi-channel AXI4-Lite potentiometer input peripheral; the parametrised successor to the single-register potentiometer input IP. It accepts NUM_CH sample streams from the ADC front end and block-averages each channel over 2^AVG_LOG2 samples. It flags new data and threshold crossings per channel, exposes everything as memory-mapped registers on S00_AXI, and raises a maskable interrupt to the PS.

## Interface
- C_S00_AXI_DATA_WIDTH, 32, AXI data width; fixed at 32.
- C_S00_AXI_ADDR_WIDTH, 6, byte address width; covers 16 registers.
- NUM_CH, 4, channel count, 1..8.
- SAMPLE_WIDTH, 12, unsigned sample width, 1..16.
- AVG_LOG2, 2, log2 of averaging block length, 0..4.

Clock and reset:
- s00_axi_aclk  in  1  sole clock; all logic on rising edge.
- s00_axi_areset  in  1  synchronous reset, active-high.

Sample inputs:
- sample_i  in  NUM_CH*SAMPLE_WIDTH  channel i at bits [i*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- sample_valid_i  in  NUM_CH  one-cycle strobe per channel.

Interrupt:
- irq_o  out  1  level interrupt, registered.

AXI4-Lite write path:
- s00_axi_awaddr  in  6
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid  in  1
- s00_axi_awready  out  1
- s00_axi_wdata  in  32
- s00_axi_wstrb  in  4
- s00_axi_wvalid  in  1
- s00_axi_wready  out  1
- s00_axi_bresp  out  2  always OKAY (00).
- s00_axi_bvalid  out  1
- s00_axi_bready  in  1

AXI4-Lite read path:
- s00_axi_araddr  in  6
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid  in  1
- s00_axi_arready  out  1
- s00_axi_rdata  out  32
- s00_axi_rresp  out  2  always OKAY (00).
- s00_axi_rvalid  out  1
- s00_axi_rready  in  1

## Operation

Register map. Byte addresses; address bits [1:0] are ignored.
- 0x00 CTRL (RW):
  - bit0 EN.
  - bit1 CLR; write-1 pulse, reads 0.
  - bits[15:8] IRQ_MASK per channel.
- 0x04 STATUS (W1C):
  - bits[NUM_CH-1:0] NEW flags.
  - bits[8+NUM_CH-1:8] THR flags.
- 0x08 THRESH (RW): bits[SAMPLE_WIDTH-1:0].
- 0x0C ID (RO): {8'h02, NUM_CH, SAMPLE_WIDTH, AVG_LOG2}, each field 8 bits.
- 0x10+4*i CH_DATA[i] (RO): averaged value, zero-extended.
- Unmapped addresses, and channels at index ≥ NUM_CH: writes ignored, reads return 0.
- wstrb is honoured per byte lane on CTRL, STATUS and THRESH.

Per-channel averaging. Each channel has an accumulator of SAMPLE_WIDTH+AVG_LOG2 bits and a counter of AVG_LOG2 bits.
- sample_valid_i[i] with EN=1 and counter < 2^AVG_LOG2−1: acc += sample, count++.
- sample_valid_i[i] with EN=1 and counter = 2^AVG_LOG2−1:
  - CH_DATA[i] ← (acc + sample) >> AVG_LOG2, truncating.
  - acc ← 0, count ← 0.
  - Set NEW[i].
  - Set THR[i] if the result is strictly greater than THRESH.
- AVG_LOG2=0: every valid sample updates CH_DATA directly.
- EN=0: strobes ignored; acc, counter and CH_DATA hold.
- CLR: next edge zeroes all acc, counters, CH_DATA, NEW and THR. Samples arriving on that edge are discarded. CTRL and THRESH are preserved.
- Simultaneous W1C and flag set on the same bit in one cycle: the set wins.
- irq_o ← |((NEW | THR) & IRQ_MASK[NUM_CH-1:0]).

Write FSM, states W_IDLE → W_RESP:
- W_IDLE: when awvalid & wvalid are both high, pulse awready and wready together for one cycle, latch the address and data, and commit the register write on that edge. Go to W_RESP.
- W_RESP: bvalid=1; held until bready, then return to W_IDLE.
- AW and W are never accepted independently. A master holding only one of them waits.

Read FSM, states R_IDLE → R_DATA:
- R_IDLE: when arvalid, pulse arready for one cycle and capture rdata from the addressed register on that edge. Go to R_DATA.
- R_DATA: rvalid=1; rdata is stable until rready, then return to R_IDLE.
- Read and write FSMs are independent; a concurrent read sees pre-write contents.

Reset: all registers, flags and accumulators go to 0, and both FSMs go to idle. Outputs during and after reset: awready, wready, bvalid, arready, rvalid, irq_o = 0; rdata, bresp, rresp = 0. Reset mid-transaction aborts it; no response is issued.

## Timing
- Write: handshake at edge N. The register value is visible to logic from cycle N+1, and bvalid rises at N+1. Minimum 2 cycles per write; throughput is 1 write per 2 cycles with bready tied high.
- Read: arready at edge N; rvalid and rdata at N+1. Minimum 2 cycles per read.
- Sample-to-data: a completing strobe at edge N updates CH_DATA, NEW and THR at N+1; irq_o rises at N+2.
- W1C at edge N: the flag clears at N+1; irq_o falls at N+2 if no other source is active.
- Back-to-back strobes on every cycle are supported on all channels simultaneously.

## Test plan
- Reset, then read ID with defaults → 0x0204_0C02. All other registers read 0; irq_o=0.
- EN=1, channel 0 strobes 100, 200, 300, 401 → CH_DATA[0]=250 one cycle after the 4th strobe. NEW[0]=1. Channels 1–3 remain 0.
- THRESH=250, IRQ_MASK=0x02, channel 1 averages to 251 → THR[1] and NEW[1] set, irq_o=1 two cycles later. Writing STATUS=0x0202 clears irq_o.
- Strobe on channel 2 completes on the same edge as a W1C of NEW[2] → NEW[2] stays 1.
- EN=0 with strobes → CH_DATA unchanged. Write CLR mid-block (2 of 4 samples taken), then 4 new samples of 8 → CH_DATA=8, with no contribution from the pre-CLR samples.
- AW valid 3 cycles before W valid, bready held low for 5 cycles → no early awready, a single handshake, bvalid held the full 5 cycles. Read of 0x3C → 0, rresp OKAY.
